// File: rtl/serial_add32_ctrl.sv
// serial_add32_ctrl: 32-bit add/subtract built from one 4-bit carry-lookahead
// slice that is reused for eight cycles, starting with the least-significant nibble.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for i_start; all outputs are held
// ST_RUN  | one nibble per cycle, r_idx 0..7; o_busy=1
// ST_DONE | result, cout and overflow are final; o_done=1 for one cycle
module serial_add32_ctrl (
   input  logic        i_clock,
   input  logic        i_clear,
   input  logic        i_start,
   input  logic        i_op_sub,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_result,
   output logic        o_cout,
   output logic        o_overflow,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_carry;
   logic [2:0]  r_idx;
   logic [31:0] r_result;
   logic        r_cout;
   logic        r_overflow;

   logic [4:0]  w_bit_ofs;
   logic [3:0]  w_nib_a;
   logic [3:0]  w_nib_b;
   logic [3:0]  w_g;
   logic [3:0]  w_p;
   logic [4:0]  w_c;
   logic [3:0]  w_sum;

   assign w_bit_ofs = {r_idx, 2'b00};
   assign w_nib_a   = r_a[w_bit_ofs +: 4];
   assign w_nib_b   = r_b[w_bit_ofs +: 4];

   // The single 4-bit carry-lookahead slice: generate/propagate, then the carries.
   always_comb begin
      w_g    = w_nib_a & w_nib_b;
      w_p    = w_nib_a ^ w_nib_b;
      w_c    = 5'd0;
      w_c[0] = r_carry;
      w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
      w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
      w_sum  = w_p ^ w_c[3:0];
   end

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_clear) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic: start only matters in IDLE, and RUN ends after nibble 7.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
         ST_RUN:  if (r_idx == 3'd7) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: latch operands on start, then fold one nibble per RUN cycle into the result.
   always_ff @(posedge i_clock) begin
      if (i_clear) begin
         r_a        <= 32'd0;
         r_b        <= 32'd0;
         r_carry    <= 1'b0;
         r_idx      <= 3'd0;
         r_result   <= 32'd0;
         r_cout     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_a      <= i_a;
                  r_b      <= i_op_sub ? ~i_b : i_b;
                  r_carry  <= i_op_sub;
                  r_idx    <= 3'd0;
                  r_result <= 32'd0;
               end
            end
            ST_RUN: begin
               r_result[w_bit_ofs +: 4] <= w_sum;
               r_carry                  <= w_c[4];
               if (r_idx != 3'd7) begin
                  r_idx <= r_idx + 3'd1;
               end else begin
                  r_idx      <= 3'd0;
                  r_cout     <= w_c[4];
                  r_overflow <= (r_a[31] == r_b[31]) & (w_sum[3] != r_a[31]);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_result   = r_result;
   assign o_cout     = r_cout;
   assign o_overflow = r_overflow;
   assign o_busy     = (r_state == ST_RUN);
   assign o_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_add32_ctrl.sv
// Bench for serial_add32_ctrl. Expected results come from a plain 33-bit
// arithmetic model and are queued when an operation is issued; a monitor pops
// one entry for every done pulse.
module tb_serial_add32_ctrl;

   typedef struct {
      logic [31:0] res;
      logic        cout;
      logic        ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic        start = 1'b0;
   logic        op_sub = 1'b0;
   logic [31:0] a_in = 32'd0;
   logic [31:0] b_in = 32'd0;
   logic [31:0] result;
   logic        cout;
   logic        overflow;
   logic        busy;
   logic        done;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_done = 0;
   exp_t q_exp[$];

   serial_add32_ctrl u_dut (
      .i_clock    (clk),
      .i_clear    (clear),
      .i_start    (start),
      .i_op_sub   (op_sub),
      .i_a        (a_in),
      .i_b        (b_in),
      .o_result   (result),
      .o_cout     (cout),
      .o_overflow (overflow),
      .o_busy     (busy),
      .o_done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic exp_t calc(input logic [31:0] a, input logic [31:0] b, input logic sub);
      exp_t        e;
      logic [31:0] bp;
      logic [32:0] full;
      bp     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bp} + {32'd0, sub};
      e.res  = full[31:0];
      e.cout = full[32];
      e.ov   = (a[31] == bp[31]) && (full[31] != a[31]);
      return e;
   endfunction

   // Monitor: busy/done exclusivity every cycle, scoreboard compare on every done.
   always @(negedge clk) begin
      exp_t e;
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
         n_done++;
         if (q_exp.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q_exp.pop_front();
            chk("result", result, e.res);
            chk("cout", {31'd0, cout}, {31'd0, e.cout});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
         end
      end
   end

   // Issue one op from IDLE (called at a negedge) and check busy and done latency.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input string tag);
      int cyc;
      q_exp.push_back(calc(a, b, sub));
      start  = 1'b1;
      op_sub = sub;
      a_in   = a;
      b_in   = b;
      @(negedge clk);
      start  = 1'b0;
      a_in   = $urandom;
      b_in   = $urandom;
      op_sub = ~sub;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      cyc = 1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'd9);
      @(negedge clk);
   endtask

   initial begin
      int          cyc;
      int          done_before;
      logic [31:0] bb_a [3];
      logic [31:0] bb_b [3];
      logic        bb_s [3];

      repeat (3) @(negedge clk);
      chk("rst_result", result, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_cout_ovf", {30'd0, cout, overflow}, 32'd0);
      clear = 1'b0;
      @(negedge clk);

      run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "add_wrap");
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, "sub_neg");
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, "sub_ovf");

      // A start pulse with different operands during RUN must be ignored.
      q_exp.push_back(calc(32'h1234_5678, 32'h1111_1111, 1'b0));
      start = 1'b1; op_sub = 1'b0; a_in = 32'h1234_5678; b_in = 32'h1111_1111;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; op_sub = 1'b1; a_in = 32'hFFFF_FFFF; b_in = 32'h0000_0001;
      @(negedge clk);
      start = 1'b0;
      cyc = 4;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("ignore_latency", 32'(cyc), 32'd9);
      @(negedge clk);
      chk("ignore_idle", {31'd0, busy}, 32'd0);

      // Clear in RUN at idx=3 abandons the op.
      start = 1'b1; op_sub = 1'b0; a_in = 32'h1111_1111; b_in = 32'h2222_2222;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_clr_busy", {31'd0, busy}, 32'd1);
      chk("pre_clr_partial", result, 32'h0000_0333);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_busy", {31'd0, busy}, 32'd0);
      chk("clr_result", result, 32'd0);
      chk("clr_done", {31'd0, done}, 32'd0);
      done_before = n_done;
      repeat (12) @(negedge clk);
      chk("clr_no_done", 32'(n_done - done_before), 32'd0);
      run_op(32'h0000_000A, 32'h0000_0005, 1'b0, "after_clr");

      // Clear wins over start in the same cycle.
      start = 1'b1; op_sub = 1'b0; a_in = 32'h5; b_in = 32'h6; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0; start = 1'b0;
      chk("clr_prio_busy", {31'd0, busy}, 32'd0);
      chk("clr_prio_result", result, 32'd0);
      @(negedge clk);
      chk("clr_prio_idle", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 6; i++)
         run_op($urandom, $urandom, 1'(i % 2), "rnd");

      // Start held high: back-to-back ops, done pulses 10 cycles apart.
      for (int i = 0; i < 3; i++) begin
         bb_a[i] = $urandom;
         bb_b[i] = $urandom;
         bb_s[i] = 1'(i % 2);
      end
      q_exp.push_back(calc(bb_a[0], bb_b[0], bb_s[0]));
      start = 1'b1; a_in = bb_a[0]; b_in = bb_b[0]; op_sub = bb_s[0];
      for (int k = 0; k < 3; k++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!done && cyc < 25);
         chk("b2b_interval", 32'(cyc), (k == 0) ? 32'd9 : 32'd10);
         if (k < 2) begin
            q_exp.push_back(calc(bb_a[k+1], bb_b[k+1], bb_s[k+1]));
            a_in = bb_a[k+1]; b_in = bb_b[k+1]; op_sub = bb_s[k+1];
         end else begin
            start = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      chk("b2b_idle", {31'd0, busy}, 32'd0);
      chk("queue_empty", 32'(q_exp.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
